// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder and the up/down counter it drives.
package quad_pkg;

   localparam logic [1:0] CTRL_HOLD = 2'b00;
   localparam logic [1:0] CTRL_INC  = 2'b01;
   localparam logic [1:0] CTRL_DEC  = 2'b10;

   typedef enum logic {S_INIT, S_RUN} quad_state_t;

   // Forward Gray successor: 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] gray_next(input logic [1:0] ph);
      logic [1:0] nx;
      case (ph)
         2'b00:   nx = 2'b01;
         2'b01:   nx = 2'b11;
         2'b11:   nx = 2'b10;
         default: nx = 2'b00;
      endcase
      return nx;
   endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: flop-chain synchroniser followed by a stability counter that only
// accepts a new level after it has been seen for FILT_CYC consecutive cycles.
module quad_glitch_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYC    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic settled
);

   localparam int unsigned CW = $clog2(FILT_CYC + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   filt_q;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];
   assign dout     = filt_q;
   assign settled  = (sync_bit == filt_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         if (cnt_q == CW'(FILT_CYC)) begin
            filt_q <= sync_bit;
            cnt_q  <= '0;
         end else if (sync_bit == filt_q) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: filtered A/B to one-cycle INC/DEC pulses plus error flag.
// Define QUAD_X1_EN to count once per full encoder cycle instead of on every edge.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYC    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_a,
   input  logic       enc_b,
   output logic [1:0] control,
   output logic       error,
   output logic [1:0] phase
);

   localparam int unsigned CW = $clog2(FILT_CYC + 1);

   logic        filt_a, filt_b;
   logic        settled_a, settled_b;
   logic [1:0]  nxt;
   logic [CW-1:0] init_cnt;
   quad_state_t state;

   quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_filt_a (
      .clk     (clk),
      .rst     (rst),
      .din     (enc_a),
      .dout    (filt_a),
      .settled (settled_a)
   );

   quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_filt_b (
      .clk     (clk),
      .rst     (rst),
      .din     (enc_b),
      .dout    (filt_b),
      .settled (settled_b)
   );

   assign nxt = {filt_a, filt_b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_INIT;
         phase    <= 2'b00;
         control  <= CTRL_HOLD;
         error    <= 1'b0;
         init_cnt <= '0;
      end else begin
         control <= CTRL_HOLD;
         error   <= 1'b0;
         case (state)
            S_INIT: begin
               // Load the starting phase silently once both channels have settled.
               if (settled_a && settled_b) begin
                  if (init_cnt == CW'(FILT_CYC - 1)) begin
                     phase    <= nxt;
                     state    <= S_RUN;
                     init_cnt <= '0;
                  end else begin
                     init_cnt <= init_cnt + CW'(1);
                  end
               end else begin
                  init_cnt <= '0;
               end
            end
            S_RUN: begin
               phase <= nxt;
               if (nxt == gray_next(phase)) begin
`ifdef QUAD_X1_EN
                  if (phase == 2'b10) control <= CTRL_INC;
`else
                  control <= CTRL_INC;
`endif
               end else if (gray_next(nxt) == phase) begin
`ifdef QUAD_X1_EN
                  if (phase == 2'b00) control <= CTRL_DEC;
`else
                  control <= CTRL_DEC;
`endif
               end else if (nxt != phase) begin
                  // Double-bit jump: flag it and resync to the new phase.
                  error <= 1'b1;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder at SYNC_STAGES=2, FILT_CYC=4; honours QUAD_X1_EN.
module tb_quad_decoder;
   import quad_pkg::*;

`ifdef QUAD_X1_EN
   localparam int EXP_FWD_INC   = 1;
   localparam int EXP_REV_DEC   = 1;
   localparam int EXP_FWD_STEP  = 3;
   localparam int EXP_JUMP_INC  = 0;
`else
   localparam int EXP_FWD_INC   = 4;
   localparam int EXP_REV_DEC   = 4;
   localparam int EXP_FWD_STEP  = 0;
   localparam int EXP_JUMP_INC  = 1;
`endif
   // Sampling edge + 2 sync + 4 filter + 1 output register, seen at the 8th negedge.
   localparam int EXP_LAT_IDX = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enc_a, enc_b;
   logic [1:0] control, phase;
   logic       error;
   int         n_cmp = 0;
   int         n_bad = 0;

   quad_decoder #(.SYNC_STAGES(2), .FILT_CYC(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .control (control),
      .error   (error),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   // Drive one level and tally what the outputs do over the following cycles.
   task automatic run_step(input logic [1:0] ab, input int cycles,
                           output int incs, output int decs, output int errs,
                           output int bad, output int first);
      logic [1:0] prev;
      prev = 2'b00; incs = 0; decs = 0; errs = 0; bad = 0; first = -1;
      {enc_a, enc_b} = ab;
      for (int i = 1; i <= cycles; i++) begin
         @(negedge clk);
         if (control == CTRL_INC) incs++;
         if (control == CTRL_DEC) decs++;
         if (error) errs++;
         if (control == 2'b11 || (control != 2'b00 && prev != 2'b00)) bad++;
         if (control != 2'b00 && first < 0) first = i;
         prev = control;
      end
   endtask

   task automatic do_reset(input logic [1:0] ab);
      {enc_a, enc_b} = ab;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int quiet_bad;
      do_reset(2'b11);
      n_cmp++;
      if ({phase, control, error} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_values: got phase=%b control=%b error=%b required 00/00/0",
                  phase, control, error);
      end
      quiet_bad = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         n_cmp++;
         if (control !== CTRL_HOLD || error !== 1'b0) begin
            n_bad++;
            $display("FAIL init_quiet: cycle %0d got control=%b error=%b required 00/0",
                     i, control, error);
         end
      end
      n_cmp++;
      if (phase !== 2'b11) begin
         n_bad++;
         $display("FAIL init_phase: got %b required 11", phase);
      end
   endtask

   task automatic test_forward();
      logic [1:0] seq [4];
      int i, d, e, b, f, ti, td, te, tb, fstep, fidx;
      seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      ti = 0; td = 0; te = 0; tb = 0; fstep = -1; fidx = -1;
      for (int k = 0; k < 4; k++) begin
         run_step(seq[k], 10, i, d, e, b, f);
         ti += i; td += d; te += e; tb += b;
         if (f >= 0 && fstep < 0) begin fstep = k; fidx = f; end
      end
      n_cmp++;
      if (ti !== EXP_FWD_INC || td !== 0) begin
         n_bad++;
         $display("FAIL fwd_count: got inc=%0d dec=%0d required inc=%0d dec=0",
                  ti, td, EXP_FWD_INC);
      end
      n_cmp++;
      if (te !== 0 || tb !== 0) begin
         n_bad++;
         $display("FAIL fwd_clean: got err=%0d bad_pulses=%0d required 0/0", te, tb);
      end
      n_cmp++;
      if (fstep !== EXP_FWD_STEP || fidx !== EXP_LAT_IDX) begin
         n_bad++;
         $display("FAIL fwd_latency: got step=%0d idx=%0d required step=%0d idx=%0d",
                  fstep, fidx, EXP_FWD_STEP, EXP_LAT_IDX);
      end
      n_cmp++;
      if (phase !== 2'b00) begin
         n_bad++;
         $display("FAIL fwd_phase: got %b required 00", phase);
      end
   endtask

   task automatic test_reverse();
      logic [1:0] seq [4];
      int i, d, e, b, f, ti, td, te, tb, fstep;
      seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      ti = 0; td = 0; te = 0; tb = 0; fstep = -1;
      for (int k = 0; k < 4; k++) begin
         run_step(seq[k], 10, i, d, e, b, f);
         ti += i; td += d; te += e; tb += b;
         if (f >= 0 && fstep < 0) fstep = k;
      end
      n_cmp++;
      if (td !== EXP_REV_DEC || ti !== 0) begin
         n_bad++;
         $display("FAIL rev_count: got dec=%0d inc=%0d required dec=%0d inc=0",
                  td, ti, EXP_REV_DEC);
      end
      n_cmp++;
      if (te !== 0 || tb !== 0) begin
         n_bad++;
         $display("FAIL rev_clean: got err=%0d bad_pulses=%0d required 0/0", te, tb);
      end
      n_cmp++;
      if (fstep !== 0) begin
         n_bad++;
         $display("FAIL rev_first_step: got %0d required 0", fstep);
      end
      n_cmp++;
      if (phase !== 2'b00) begin
         n_bad++;
         $display("FAIL rev_phase: got %b required 00", phase);
      end
   endtask

   task automatic test_glitch();
      int i, d, e, b, f, i2, d2, e2, b2, f2;
      run_step(2'b10, 3, i, d, e, b, f);
      run_step(2'b00, 15, i2, d2, e2, b2, f2);
      n_cmp++;
      if (i + d + i2 + d2 !== 0 || e + e2 !== 0) begin
         n_bad++;
         $display("FAIL glitch_quiet: got pulses=%0d errs=%0d required 0/0",
                  i + d + i2 + d2, e + e2);
      end
      n_cmp++;
      if (phase !== 2'b00) begin
         n_bad++;
         $display("FAIL glitch_phase: got %b required 00", phase);
      end
   endtask

   task automatic test_double_jump();
      int i, d, e, b, f;
      run_step(2'b11, 12, i, d, e, b, f);
      n_cmp++;
      if (e !== 1 || i + d !== 0) begin
         n_bad++;
         $display("FAIL jump_error: got errs=%0d pulses=%0d required 1/0", e, i + d);
      end
      n_cmp++;
      if (phase !== 2'b11) begin
         n_bad++;
         $display("FAIL jump_phase: got %b required 11", phase);
      end
      run_step(2'b10, 12, i, d, e, b, f);
      n_cmp++;
      if (i !== EXP_JUMP_INC || d !== 0 || e !== 0) begin
         n_bad++;
         $display("FAIL jump_recover: got inc=%0d dec=%0d err=%0d required %0d/0/0",
                  i, d, e, EXP_JUMP_INC);
      end
   endtask

   task automatic test_mid_reset();
      int i, d, e, b, f;
      run_step(2'b11, 12, i, d, e, b, f);
      n_cmp++;
      if (phase !== 2'b11) begin
         n_bad++;
         $display("FAIL pre_reset_phase: got %b required 11", phase);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({phase, control, error} !== 5'b0) begin
         n_bad++;
         $display("FAIL async_reset: got phase=%b control=%b error=%b required 00/00/0",
                  phase, control, error);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_step(2'b11, 30, i, d, e, b, f);
      n_cmp++;
      if (i + d !== 0 || e !== 0) begin
         n_bad++;
         $display("FAIL post_reset_quiet: got pulses=%0d errs=%0d required 0/0", i + d, e);
      end
      n_cmp++;
      if (phase !== 2'b11) begin
         n_bad++;
         $display("FAIL post_reset_phase: got %b required 11", phase);
      end
   endtask

   initial begin
      rst = 1'b1;
      enc_a = 1'b1;
      enc_b = 1'b1;
      test_reset();
      do_reset(2'b00);
      repeat (12) @(negedge clk);
      test_forward();
      test_reverse();
      test_glitch();
      test_double_jump();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
